// File: rtl/vx_split_join_ctrl_pkg.sv
// Shared types for the split/join reconvergence controller.
package vx_split_join_ctrl_pkg;

    localparam int DEF_THREADS = 4;
    localparam int DEF_PC_BITS = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RSP  = 1'b1
    } sj_state_e;

    // Reconvergence stack entry at default widths; the stack stores the
    // same {tmask, pc} layout as a flat vector so other widths also work.
    typedef struct packed {
        logic [DEF_THREADS-1:0] tmask;
        logic [DEF_PC_BITS-1:0] pc;
    } stk_entry_t;

endpackage

// File: rtl/vx_split_join_ctrl_ipdom_stack.sv
// Immediate-post-dominator stack. Each slot holds a pair of entries (q1, q2).
// A paired push returns q2 on its first pop and q1 on its second pop.
module VX_ipdom_stack #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             pair,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] d,
    output logic             index,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_q1 [DEPTH];
    logic [WIDTH-1:0] r_q2 [DEPTH];
    logic [DEPTH-1:0] r_part;
    logic [AW-1:0]    w_wr;
    logic [AW-1:0]    w_top;

    assign w_wr  = r_count[AW-1:0];
    assign w_top = r_count[AW-1:0] - 1'b1;
    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign index = r_part[w_top];
    assign d     = r_part[w_top] ? r_q1[w_top] : r_q2[w_top];

    // Occupancy: a pop only releases the slot once its second half is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + 1'b1;
        end else if (pop && !empty && r_part[w_top]) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Entry storage and per-slot "already half consumed" flag.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_q1[w_wr]   <= q1;
            r_q2[w_wr]   <= q2;
            r_part[w_wr] <= ~pair;
        end else if (pop && !empty && !r_part[w_top]) begin
            r_part[w_top] <= 1'b1;
        end
    end

endmodule

// File: rtl/vx_split_join_ctrl.sv
// Split/join control: pushes reconvergence masks on divergent branches and
// replays them on joins, returning one response per accepted request.
module vx_split_join_ctrl
    import vx_split_join_ctrl_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   split_valid,
    output logic                   split_ready,
    input  logic [NUM_THREADS-1:0] split_tmask,
    input  logic [NUM_THREADS-1:0] split_taken,
    input  logic [PC_BITS-1:0]     split_pc,
    input  logic                   join_valid,
    output logic                   join_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NUM_THREADS-1:0] rsp_tmask,
    output logic [PC_BITS-1:0]     rsp_pc,
    output logic                   rsp_jump,
    output logic                   rsp_err,
    output logic                   stk_empty,
    output logic                   stk_full,
    output logic                   err_underflow
);
    localparam int W = NUM_THREADS + PC_BITS;

    sj_state_e              r_state, w_state_nxt;
    logic [NUM_THREADS-1:0] r_rsp_tmask;
    logic [PC_BITS-1:0]     r_rsp_pc;
    logic                   r_rsp_jump, r_rsp_err, r_err_underflow;

    logic                   w_split_acc, w_join_acc, w_push, w_pop, w_pair;
    logic [NUM_THREADS-1:0] w_taken_m, w_else_m;
    logic [W-1:0]           w_q1, w_q2, w_d;
    logic                   w_index, w_empty, w_full;

    assign w_taken_m   = split_tmask & split_taken;
    assign w_else_m    = split_tmask & ~split_taken;
    assign w_pair      = (|w_taken_m) && (|w_else_m);
    assign w_split_acc = split_valid && split_ready;
    assign w_join_acc  = join_valid && join_ready;
    assign w_push      = w_split_acc;
    assign w_pop       = w_join_acc && !w_empty;
    assign w_q1        = {split_tmask, {PC_BITS{1'b0}}};
    assign w_q2        = {w_else_m, split_pc};

    VX_ipdom_stack #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (~reset_n),
        .push  (w_push),
        .pop   (w_pop),
        .pair  (w_pair),
        .q1    (w_q1),
        .q2    (w_q2),
        .d     (w_d),
        .index (w_index),
        .empty (w_empty),
        .full  (w_full)
    );

    assign stk_empty     = w_empty;
    assign stk_full      = w_full;
    assign rsp_valid     = (r_state == S_RSP);
    assign rsp_tmask     = r_rsp_tmask;
    assign rsp_pc        = r_rsp_pc;
    assign rsp_jump      = r_rsp_jump;
    assign rsp_err       = r_rsp_err;
    assign err_underflow = r_err_underflow;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and request handshakes; split has priority over join.
    always_comb begin
        w_state_nxt = r_state;
        split_ready = 1'b0;
        join_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                split_ready = ~w_full;
                join_ready  = ~split_valid;
                if ((split_valid && ~w_full) || (join_valid && ~split_valid))
                    w_state_nxt = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response payload captured at accept and held through the RSP state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_tmask     <= '0;
            r_rsp_pc        <= '0;
            r_rsp_jump      <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_err_underflow <= 1'b0;
        end else if (w_split_acc) begin
            r_rsp_tmask <= w_pair ? w_taken_m : split_tmask;
            r_rsp_pc    <= '0;
            r_rsp_jump  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_join_acc) begin
            if (w_empty) begin
                r_rsp_tmask     <= '0;
                r_rsp_pc        <= '0;
                r_rsp_jump      <= 1'b0;
                r_rsp_err       <= 1'b1;
                r_err_underflow <= 1'b1;
            end else begin
                r_rsp_tmask <= w_d[W-1:PC_BITS];
                r_rsp_pc    <= w_index ? '0 : w_d[PC_BITS-1:0];
                r_rsp_jump  <= ~w_index;
                r_rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vx_split_join_ctrl.sv
module tb_vx_split_join_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        split_valid = 1'b0, split_ready;
    logic [3:0]  split_tmask = '0, split_taken = '0;
    logic [31:0] split_pc = '0;
    logic        join_valid = 1'b0, join_ready;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [3:0]  rsp_tmask;
    logic [31:0] rsp_pc;
    logic        rsp_jump, rsp_err, stk_empty, stk_full, err_underflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vx_split_join_ctrl #(.NUM_THREADS(4), .PC_BITS(32), .DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .split_valid   (split_valid),
        .split_ready   (split_ready),
        .split_tmask   (split_tmask),
        .split_taken   (split_taken),
        .split_pc      (split_pc),
        .join_valid    (join_valid),
        .join_ready    (join_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tmask     (rsp_tmask),
        .rsp_pc        (rsp_pc),
        .rsp_jump      (rsp_jump),
        .rsp_err       (rsp_err),
        .stk_empty     (stk_empty),
        .stk_full      (stk_full),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_split(input logic [3:0] tm, input logic [3:0] tk, input logic [31:0] pc);
        int n;
        split_tmask = tm; split_taken = tk; split_pc = pc; split_valid = 1'b1;
        n = 0;
        #1;
        while (!split_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("split_accept", 64'(split_ready), 64'd1);
        @(posedge clk); #1;
        split_valid = 1'b0;
    endtask

    task automatic send_join();
        int n;
        join_valid = 1'b1;
        n = 0;
        #1;
        while (!join_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("join_accept", 64'(join_ready), 64'd1);
        @(posedge clk); #1;
        join_valid = 1'b0;
    endtask

    task automatic take_rsp(input string tag, input logic [3:0] tm, input logic [31:0] pc,
                            input logic jump, input logic err);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_tmask"}, 64'(rsp_tmask), 64'(tm));
        chk({tag, "_pc"},    64'(rsp_pc),    64'(pc));
        chk({tag, "_jump"},  64'(rsp_jump),  64'(jump));
        chk({tag, "_err"},   64'(rsp_err),   64'(err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_done"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_empty", 64'(stk_empty), 64'd1);
        chk("rst_full",  64'(stk_full),  64'd0);
        chk("rst_uflow", 64'(err_underflow), 64'd0);
        chk("rst_tmask", 64'(rsp_tmask), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_split_ready", 64'(split_ready), 64'd1);
        chk("idle_join_ready",  64'(join_ready),  64'd1);

        // divergent split then two joins
        send_split(4'b1111, 4'b0011, 32'h100);
        take_rsp("div_split", 4'b0011, 32'h0, 1'b0, 1'b0);
        chk("div_not_empty", 64'(stk_empty), 64'd0);
        send_join();
        take_rsp("div_join0", 4'b1100, 32'h100, 1'b1, 1'b0);
        send_join();
        take_rsp("div_join1", 4'b1111, 32'h0, 1'b0, 1'b0);
        chk("div_empty", 64'(stk_empty), 64'd1);

        // uniform split then one join
        send_split(4'b1010, 4'b1111, 32'h55);
        take_rsp("uni_split", 4'b1010, 32'h0, 1'b0, 1'b0);
        send_join();
        take_rsp("uni_join", 4'b1010, 32'h0, 1'b0, 1'b0);
        chk("uni_empty", 64'(stk_empty), 64'd1);

        // simultaneous split and join: join_ready drops, split wins
        split_valid = 1'b1; join_valid = 1'b1;
        split_tmask = 4'b0101; split_taken = 4'b0101; split_pc = 32'h0;
        #1;
        chk("prio_join_ready", 64'(join_ready), 64'd0);
        @(posedge clk); #1;
        split_valid = 1'b0; join_valid = 1'b0;
        take_rsp("prio_split", 4'b0101, 32'h0, 1'b0, 1'b0);
        send_join();
        take_rsp("prio_join", 4'b0101, 32'h0, 1'b0, 1'b0);

        // fill the stack
        for (int i = 0; i < 4; i++) begin
            send_split(4'b1111, 4'b1111, 32'h0);
            take_rsp("fill", 4'b1111, 32'h0, 1'b0, 1'b0);
        end
        chk("full_flag", 64'(stk_full), 64'd1);
        chk("full_split_ready", 64'(split_ready), 64'd0);
        split_tmask = 4'b0110; split_taken = 4'b0010; split_pc = 32'h200;
        split_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_no_rsp", 64'(rsp_valid), 64'd0);
            chk("stall_full", 64'(stk_full), 64'd1);
        end
        split_valid = 1'b0;
        send_join();
        take_rsp("free_join", 4'b1111, 32'h0, 1'b0, 1'b0);
        chk("free_not_full", 64'(stk_full), 64'd0);
        send_split(4'b0110, 4'b0010, 32'h200);
        take_rsp("fifth_split", 4'b0010, 32'h0, 1'b0, 1'b0);
        chk("refull", 64'(stk_full), 64'd1);
        send_join();
        take_rsp("drain_else", 4'b0100, 32'h200, 1'b1, 1'b0);
        send_join();
        take_rsp("drain_saved", 4'b0110, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_join();
            take_rsp("drain_uni", 4'b1111, 32'h0, 1'b0, 1'b0);
        end
        chk("drain_empty", 64'(stk_empty), 64'd1);

        // backpressure on response
        send_split(4'b1000, 4'b0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_tmask", 64'(rsp_tmask), 64'h8);
            chk("bp_split_ready", 64'(split_ready), 64'd0);
            chk("bp_join_ready", 64'(join_ready), 64'd0);
            @(posedge clk); #1;
        end
        take_rsp("bp_rsp", 4'b1000, 32'h0, 1'b0, 1'b0);
        send_join();
        take_rsp("bp_join", 4'b1000, 32'h0, 1'b0, 1'b0);

        // underflow
        chk("pre_uflow", 64'(err_underflow), 64'd0);
        send_join();
        take_rsp("uflow_rsp", 4'b0000, 32'h0, 1'b0, 1'b1);
        chk("uflow_sticky", 64'(err_underflow), 64'd1);
        chk("uflow_empty", 64'(stk_empty), 64'd1);
        send_split(4'b0011, 4'b0011, 32'h0);
        take_rsp("uflow_after", 4'b0011, 32'h0, 1'b0, 1'b0);
        chk("uflow_still", 64'(err_underflow), 64'd1);

        // reset while in RSP with two entries on the stack
        send_split(4'b1111, 4'b0001, 32'h300);
        chk("rstmid_valid", 64'(rsp_valid), 64'd1);
        chk("rstmid_depth", 64'(stk_empty), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("rstmid_drop", 64'(rsp_valid), 64'd0);
        chk("rstmid_empty", 64'(stk_empty), 64'd1);
        chk("rstmid_uflow", 64'(err_underflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_empty", 64'(stk_empty), 64'd1);
        chk("post_rst_full", 64'(stk_full), 64'd0);
        send_join();
        take_rsp("post_rst_join", 4'b0000, 32'h0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
